// File: rtl/alu_pkg.sv
// Shared widths, select encodings and FSM state type for the ALU command sequencer.
package alu_pkg;
    localparam int OP_W  = 3;
    localparam int SEL_W = 2;
    localparam int RES_W = 6;

    localparam logic [SEL_W-1:0] SEL_ADD = 2'b00;
    localparam logic [SEL_W-1:0] SEL_SUB = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MUL = 2'b10;
    localparam logic [SEL_W-1:0] SEL_DIV = 2'b11;

    localparam logic [RES_W-1:0] DIV0_RESULT = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO: registered storage, power-of-two depth, head visible combinationally.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = RES_W + 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_pop,
    output logic [W-1:0]     o_rdata,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A push into a full FIFO is still legal when the same edge frees a slot.
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Registered front end for arithmetic_unit: accepts command bytes, drives operands,
// captures the result (with divide-by-zero flag) and queues it for a downstream consumer.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             cmd_data,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    output logic [OP_W-1:0]        alu_a,
    output logic [OP_W-1:0]        alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [RES_W-1:0]       alu_result,
    output logic [RES_W-1:0]       res_data,
    output logic                   res_err,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    state_t            r_state;
    state_t            w_next_state;
    logic [OP_W-1:0]   r_alu_a;
    logic [OP_W-1:0]   r_alu_b;
    logic [SEL_W-1:0]  r_alu_sel;
    logic [RES_W-1:0]  r_res_q;
    logic              r_err_q;
    logic              w_accept;
    logic              w_push;
    logic              w_div0;
    logic [RES_W:0]    w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // cmd_ready depends only on state and occupancy, never on cmd_valid.
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        w_push       = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = (fifo_count < FULL_CNT);
                if (cmd_valid && cmd_ready) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                w_push       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept = cmd_valid && cmd_ready;
    assign w_div0   = (r_alu_sel == SEL_DIV) && (r_alu_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= '0;
            r_res_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= cmd_data[OP_W-1:0];
                r_alu_b   <= cmd_data[2*OP_W-1:OP_W];
                r_alu_sel <= cmd_data[7:6];
            end
            if (r_state == ST_EXEC) begin
                r_res_q <= w_div0 ? DIV0_RESULT : alu_result;
                r_err_q <= w_div0;
            end
        end
    end

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (RES_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_err_q, r_res_q}),
        .i_pop   (res_ready),
        .o_rdata (w_head),
        .o_valid (res_valid),
        .o_count (fifo_count)
    );

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_sel  = r_alu_sel;
    assign res_data = w_head[RES_W-1:0];
    assign res_err  = w_head[RES_W];
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural arithmetic_unit in the loop.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_sel;
    logic [5:0] alu_result;
    logic [5:0] res_data;
    logic       res_err;
    logic       res_valid;
    logic       res_ready;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] cmd;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] sel;
        logic [5:0] res;
        logic       err;
    } vec_t;

    vec_t vecs [5];

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural arithmetic_unit; divide by zero returns a junk value the DUT must ignore.
    always_comb begin
        alu_result = 6'h00;
        case (alu_sel)
            2'b00: alu_result = {3'b000, alu_a} + {3'b000, alu_b};
            2'b01: alu_result = {3'b000, alu_a} - {3'b000, alu_b};
            2'b10: alu_result = {3'b000, alu_a} * {3'b000, alu_b};
            2'b11: alu_result = (alu_b == 3'd0) ? 6'h15 : ({3'b000, alu_a} / {3'b000, alu_b});
            default: alu_result = 6'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Returns at 1ns after the accepting edge with cmd_valid dropped.
    task automatic send(input logic [7:0] c);
        bit ok;
        bit rdy;
        ok = 1'b0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        cmd_data  = ~c;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic pop_check(input string name, input logic [5:0] d, input logic e);
        chk({name, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({name, "_data"}, {26'd0, res_data}, {26'd0, d});
        chk({name, "_err"}, {31'd0, res_err}, {31'd0, e});
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_alu"}, {24'd0, alu_sel, alu_b, alu_a}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_data"}, {26'd0, res_data}, 32'd0);
        chk({tag, "_res_err"}, {31'd0, res_err}, 32'd0);
        chk({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{cmd: 8'h1D, a: 3'd5, b: 3'd3, sel: 2'b00, res: 6'h08, err: 1'b0};
        vecs[1] = '{cmd: 8'hBF, a: 3'd7, b: 3'd7, sel: 2'b10, res: 6'h31, err: 1'b0};
        vecs[2] = '{cmd: 8'h6A, a: 3'd2, b: 3'd5, sel: 2'b01, res: 6'h3D, err: 1'b0};
        vecs[3] = '{cmd: 8'hD7, a: 3'd7, b: 3'd2, sel: 2'b11, res: 6'h03, err: 1'b0};
        vecs[4] = '{cmd: 8'hC6, a: 3'd6, b: 3'd0, sel: 2'b11, res: 6'h3F, err: 1'b1};

        rst_n     = 1'b0;
        cmd_data  = 8'h00;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single commands with full latency profile.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].cmd);
            chk($sformatf("v%0d_alu_a", i), {29'd0, alu_a}, {29'd0, vecs[i].a});
            chk($sformatf("v%0d_alu_b", i), {29'd0, alu_b}, {29'd0, vecs[i].b});
            chk($sformatf("v%0d_alu_sel", i), {30'd0, alu_sel}, {30'd0, vecs[i].sel});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("v%0d_rdy_n0", i), {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rdy_n1", i), {31'd0, cmd_ready}, 32'd0);
            chk($sformatf("v%0d_rv_n1", i), {31'd0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rdy_n2", i), {31'd0, cmd_ready}, 32'd1);
            chk($sformatf("v%0d_count", i), {29'd0, fifo_count}, 32'd1);
            pop_check($sformatf("v%0d", i), vecs[i].res, vecs[i].err);
            chk($sformatf("v%0d_empty", i), {31'd0, res_valid}, 32'd0);
        end

        // Back-to-back mul then sub: ready low exactly two cycles after each accept.
        for (int j = 0; j < 2; j++) begin
            send(j == 0 ? 8'hBF : 8'h6A);
            chk($sformatf("b2b%0d_rdy0", j), {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_rdy1", j), {31'd0, cmd_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_rdy2", j), {31'd0, cmd_ready}, 32'd1);
        end
        chk("b2b_count", {29'd0, fifo_count}, 32'd2);
        pop_check("b2b_first", 6'h31, 1'b0);
        pop_check("b2b_second", 6'h3D, 1'b0);

        // Fill the FIFO, stall a fifth command, release it with one pop.
        for (int i = 0; i < 4; i++) begin
            send({2'b00, 3'd1, 3'(i + 1)});
        end
        wait_idle();
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_data  = 8'h3F;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("full_stall_busy", {31'd0, busy}, 32'd0);
        chk("full_stall_count", {29'd0, fifo_count}, 32'd4);
        chk("full_head", {26'd0, res_data}, 32'h02);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("full_pop_ready", {31'd0, cmd_ready}, 32'd1);
        chk("full_pop_count", {29'd0, fifo_count}, 32'd3);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("full_fifth_busy", {31'd0, busy}, 32'd1);
        chk("full_fifth_a", {29'd0, alu_a}, 32'd7);
        wait_idle();
        chk("full_refill", {29'd0, fifo_count}, 32'd4);
        pop_check("drain0", 6'h03, 1'b0);
        pop_check("drain1", 6'h04, 1'b0);
        pop_check("drain2", 6'h05, 1'b0);
        pop_check("drain3", 6'h0E, 1'b0);
        chk("drain_empty", {31'd0, res_valid}, 32'd0);

        // Push and pop on the same WRITE edge.
        send(8'h09);
        wait_idle();
        chk("pp_pre_count", {29'd0, fifo_count}, 32'd1);
        send(8'h12);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("pp_count", {29'd0, fifo_count}, 32'd1);
        pop_check("pp_head", 6'h04, 1'b0);
        chk("pp_empty", {31'd0, res_valid}, 32'd0);

        // Asynchronous reset during EXEC with two results buffered.
        send(8'h09);
        wait_idle();
        send(8'h12);
        wait_idle();
        chk("rst_pre_count", {29'd0, fifo_count}, 32'd2);
        send(8'h1D);
        chk("rst_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hD7);
        wait_idle();
        chk("post_rst_count", {29'd0, fifo_count}, 32'd1);
        pop_check("post_rst", 6'h03, 1'b0);
        chk("post_rst_empty", {31'd0, res_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
